// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - round-robin arbiter serialising I/D L1 line traffic onto one L2 port
module l1_l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              last_grant_d;  // 1 = D-cache owned the most recent grant
  logic [ADDR_W-1:0] lat_address;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;     // latched op: 1 = write, 0 = read
  logic              grant;
  logic              grant_d;

  logic i_req;
  logic d_req;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  // Arbitration and next-state: grants only from IDLE, ties go opposite to last_grant
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant   = 1'b1;
          grant_d = ~last_grant_d;
        end else if (i_req) begin
          grant   = 1'b1;
          grant_d = 1'b0;
        end else if (d_req) begin
          grant   = 1'b1;
          grant_d = 1'b1;
        end
        if (grant) begin
          next_state = grant_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus the transaction latch captured at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      lat_address  <= '0;
      lat_wdata    <= '0;
      lat_write    <= 1'b0;
    end else begin
      state <= next_state;
      if (grant) begin
        last_grant_d <= grant_d;
        lat_address  <= grant_d ? d_pmem_address : i_pmem_address;
        lat_wdata    <= grant_d ? d_pmem_wdata : i_pmem_wdata;
        // read and write both high counts as a write
        lat_write    <= grant_d ? d_pmem_write : i_pmem_write;
      end
    end
  end

  // L2 side is driven purely from flops so requester changes cannot leak through
  assign l2_read    = (state != IDLE) && !lat_write;
  assign l2_write   = (state != IDLE) && lat_write;
  assign l2_address = lat_address;
  assign l2_wdata   = lat_wdata;

  // Read data fans out to both caches; only the owner's resp qualifies it
  assign i_pmem_rdata = l2_rdata;
  assign d_pmem_rdata = l2_rdata;
  assign i_pmem_resp  = (state == SERVE_I) && l2_resp;
  assign d_pmem_resp  = (state == SERVE_D) && l2_resp;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - directed and randomized bench for l1_l2_arbiter against a transaction-level model
module tb_l1_l2_arbiter;

  logic         clk;
  logic         rst_n;
  logic [15:0]  i_pmem_address;
  logic         i_pmem_read;
  logic         i_pmem_write;
  logic [127:0] i_pmem_wdata;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [15:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [15:0]  l2_address;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  l1_l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_wdata(i_pmem_wdata), .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // requester model, index 0 = I-cache, 1 = D-cache
  logic         hv [2];
  logic         rd [2];
  logic         wr [2];
  logic [15:0]  ad [2];
  logic [127:0] wd [2];
  int           resp_cnt [2];

  // transaction-level view of the arbiter: who owns the L2 and what it must see
  bit           m_busy;
  bit           cur_busy;
  int           m_owner;
  int           m_last;
  logic [15:0]  m_addr;
  logic         m_wr;
  logic [127:0] m_wdata;
  int           lat;
  int           grants [$];

  bit           rand_en;
  bit           stray_force;
  int           fixed_lat;
  bit           use_fix;
  logic [127:0] rdata_fix;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [15:0] a, input logic r, input logic w, input logic [127:0] d);
    hv[p] = 1'b1;
    ad[p] = a;
    rd[p] = r;
    wr[p] = w;
    wd[p] = d;
  endtask

  task automatic rand_req(input int p);
    int op;
    op = $urandom_range(0, 2);
    set_req(p, 16'($urandom), op != 1, op != 0, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic drive_ports();
    i_pmem_address = ad[0];
    i_pmem_read    = hv[0] & rd[0];
    i_pmem_write   = hv[0] & wr[0];
    i_pmem_wdata   = wd[0];
    d_pmem_address = ad[1];
    d_pmem_read    = hv[1] & rd[1];
    d_pmem_write   = hv[1] & wr[1];
    d_pmem_wdata   = wd[1];
  endtask

  // One clock: drive requesters and L2, then check outputs against the model
  task automatic cycle();
    int w;
    @(posedge clk);
    #2;
    if (rand_en) begin
      for (int p = 0; p < 2; p++)
        if (!hv[p] && $urandom_range(0, 2) == 0) rand_req(p);
    end
    drive_ports();
    if (m_busy) begin
      if (lat == 0) l2_resp = 1'b1;
      else begin
        l2_resp = 1'b0;
        lat--;
      end
    end else begin
      l2_resp = stray_force | (rand_en && $urandom_range(0, 7) == 0);
    end
    l2_rdata = use_fix ? rdata_fix : {$urandom, $urandom, $urandom, $urandom};
    #1;
    cur_busy = m_busy;
    if (!m_busy) begin
      check("idle_read", 128'(l2_read), 128'(0));
      check("idle_write", 128'(l2_write), 128'(0));
      check("idle_i_resp", 128'(i_pmem_resp), 128'(0));
      check("idle_d_resp", 128'(d_pmem_resp), 128'(0));
      if (hv[0] || hv[1]) begin
        if (hv[0] && hv[1]) w = 1 - m_last;
        else w = hv[1] ? 1 : 0;
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
        m_addr  = ad[w];
        m_wr    = wr[w];
        m_wdata = wd[w];
        lat     = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        grants.push_back(w);
      end
    end else begin
      check("busy_read", 128'(l2_read), 128'(!m_wr));
      check("busy_write", 128'(l2_write), 128'(m_wr));
      check("busy_addr", 128'(l2_address), 128'(m_addr));
      check("busy_wdata", l2_wdata, m_wdata);
      check("i_resp_route", 128'(i_pmem_resp), 128'(l2_resp && m_owner == 0));
      check("d_resp_route", 128'(d_pmem_resp), 128'(l2_resp && m_owner == 1));
      if (l2_resp) begin
        check("resp_rdata", (m_owner == 0) ? i_pmem_rdata : d_pmem_rdata, l2_rdata);
        resp_cnt[m_owner]++;
        hv[m_owner] = 1'b0;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      hv[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; resp_cnt[p] = 0;
    end
    m_busy = 1'b0;
    m_last = 1;
    lat    = 0;
    grants.delete();
    drive_ports();
    l2_resp  = 1'b0;
    l2_rdata = '0;
  endtask

  // Assert reset away from a clock edge, check outputs collapse at once, then release
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    l2_resp = 1'b1;
    #1;
    check("rst_l2_read", 128'(l2_read), 128'(0));
    check("rst_l2_write", 128'(l2_write), 128'(0));
    check("rst_i_resp", 128'(i_pmem_resp), 128'(0));
    check("rst_d_resp", 128'(d_pmem_resp), 128'(0));
    check("rst_l2_addr", 128'(l2_address), 128'(0));
    check("rst_l2_wdata", l2_wdata, 128'(0));
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || hv[0] || hv[1]) && n < 60) begin
      cycle();
      n++;
    end
    check("drain_timeout", 128'(m_busy || hv[0] || hv[1]), 128'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rand_en = 1'b0;
    stray_force = 1'b0;
    fixed_lat = -1;
    use_fix = 1'b0;
    rdata_fix = '0;
    clear_model();

    // reset state
    do_reset();

    // single I read, L2 answers 3 cycles after l2_read rises
    set_req(0, 16'h1230, 1'b1, 1'b0, '0);
    fixed_lat = 3;
    use_fix = 1'b1;
    rdata_fix = {16{8'hA5}};
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 1) check("single_addr_c1", 128'(l2_address), 128'(16'h1230));
      if (k == 1) check("single_read_c1", 128'(l2_read), 128'(1));
    end
    check("single_i_resp_cnt", 128'(resp_cnt[0]), 128'(1));
    check("single_d_resp_cnt", 128'(resp_cnt[1]), 128'(0));
    use_fix = 1'b0;
    drain();

    // stray l2_resp in IDLE with nothing pending
    stray_force = 1'b1;
    cycle();
    stray_force = 1'b0;
    cycle();
    check("stray_stays_idle", 128'(cur_busy), 128'(0));

    // contention straight out of reset: I first, one idle gap, then D write
    do_reset();
    fixed_lat = 2;
    set_req(0, 16'h0100, 1'b1, 1'b0, '0);
    set_req(1, 16'h8000, 1'b0, 1'b1, {8{16'h1234}});
    drain();
    check("cont_grant_cnt", 128'(grants.size()), 128'(2));
    check("cont_first_i", 128'(grants[0]), 128'(0));
    check("cont_second_d", 128'(grants[1]), 128'(1));

    // sustained contention: both re-request at once, six grants alternate
    do_reset();
    fixed_lat = -1;
    n = 0;
    while (grants.size() < 6 && n < 200) begin
      for (int p = 0; p < 2; p++)
        if (!hv[p]) set_req(p, 16'($urandom), 1'b1, 1'b0, '0);
      cycle();
      n++;
    end
    check("rr_timeout", 128'(grants.size() >= 6), 128'(1));
    for (int k = 0; k < 6; k++) check($sformatf("rr_order_%0d", k), 128'(grants[k]), 128'(k % 2));
    drain();

    // requester changes its address mid-transaction
    fixed_lat = 4;
    set_req(1, 16'h8000, 1'b1, 1'b0, '0);
    cycle();
    ad[1] = 16'h9000;
    n = 0;
    while (m_busy && n < 20) begin
      cycle();
      if (cur_busy) check("hold_addr", 128'(l2_address), 128'(16'h8000));
      n++;
    end
    check("hold_timeout", 128'(m_busy), 128'(0));

    // reset while l2_read is high, then a tie must go to I
    fixed_lat = 6;
    set_req(0, 16'h4444, 1'b1, 1'b0, '0);
    cycle();
    cycle();
    check("pre_rst_read", 128'(l2_read), 128'(1));
    do_reset();
    fixed_lat = 1;
    set_req(0, 16'h0AAA, 1'b1, 1'b0, '0);
    set_req(1, 16'h0BBB, 1'b1, 1'b0, '0);
    drain();
    check("post_rst_tie_i", 128'(grants[0]), 128'(0));

    // randomized traffic with random ops, latencies and stray responses
    rand_en = 1'b1;
    fixed_lat = -1;
    for (int k = 0; k < 3000; k++) cycle();
    rand_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Arbiter that sits directly downstream of the split L1 caches and upstream of the unified L2. It takes the two L1 physical-memory ports (instruction cache, data cache), serialises their 128-bit line reads and write-backs onto the single L2 port, and returns each response only to the requester that owns the transaction. Arbitration is round-robin on contention. Exactly one transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 16, byte address width (lc3b_word)
- LINE_W, 128, line width (lc3b_cache_size)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, no other clock domains
- i_pmem_address  in  16  I-cache line address
- i_pmem_read  in  1  I-cache line read request
- i_pmem_write  in  1  I-cache write request (tied 0 in the current core, still fully supported)
- i_pmem_wdata  in  128  I-cache write data
- i_pmem_rdata  out  128  line returned to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata, d_pmem_rdata, d_pmem_resp: same widths and meanings, for the D-cache
- l2_address  out  16  address to L2
- l2_read  out  1  L2 read strobe
- l2_write  out  1  L2 write strobe
- l2_wdata  out  128  write data to L2
- l2_rdata  in  128  line from L2
- l2_resp  in  1  L2 transaction complete, single-cycle pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- Requester protocol: a requester holds read/write, address, and wdata stable from assertion until the cycle its resp is high. It drops the request in the cycle after resp.
- A port "requests" when read | write is high. If read and write are both high, the transaction is a write.
- IDLE behaviour:
  - No request: stay in IDLE.
  - Exactly one port requesting: grant that port.
  - Both ports requesting: grant the port opposite to last_grant.
- On grant:
  - Latch the granted port's address, wdata, and op (read or write) into internal registers.
  - Set last_grant to that port.
  - Move to SERVE_x.
- SERVE_x behaviour:
  - l2_address, l2_wdata, l2_read, and l2_write are driven only from the latched registers. Requester changes have no effect mid-transaction.
  - The other port's request waits; it is never dropped.
- Response routing:
  - In SERVE_x with l2_resp=1: x_pmem_resp=1 combinationally in the same cycle, and x_pmem_rdata = l2_rdata. Next state is IDLE.
  - The non-granted port's resp is always 0.
  - Both rdata outputs may carry l2_rdata at all times; only resp qualifies them.
- l2_resp in IDLE is ignored and causes no state change.
- Reset values: state=IDLE; last_grant=D, so an I-cache request wins the first tie; latched address, wdata, and op = 0.
  - Outputs during reset: l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
- Reset mid-transaction: outputs drop immediately on assertion of rst_n and the pending transaction is abandoned. The whole memory system shares rst_n, so the L2 also aborts.
- Fairness: under continuous contention, grants alternate I, D, I, D. Neither port waits more than one foreign transaction.

## Timing
- Request first seen high in IDLE at cycle 0: grant at edge 0→1. l2_read/l2_write are high from cycle 1, driven from flops with no combinational path from requester inputs.
- Total requester latency = 1 + L2 latency. resp arrives in the same cycle as l2_resp.
- l2_resp in cycle N: state is IDLE in cycle N+1, with l2_read and l2_write low in N+1. The next grant takes effect at edge N+1→N+2.
  - This guarantees at least one deasserted cycle between L2 transactions.
- A requester that re-requests immediately after its own resp competes in IDLE under the round-robin rule. It does not win automatically.
- Simultaneous arrival of both requests in the same IDLE cycle resolves purely by last_grant.

## Test plan
- Single I read: i_pmem_read=1, addr 0x1230; L2 responds 3 cycles after l2_read rises with 0xA5…A5. Required:
  - l2_read=1 and l2_address=0x1230 from cycle 1.
  - i_pmem_resp=1 with i_pmem_rdata=0xA5…A5 in the l2_resp cycle.
  - d_pmem_resp=0 throughout.
- Contention from reset: I read 0x0100 and D write 0x8000 with wdata 0x1234… asserted in the same cycle. Required:
  - I is granted first.
  - After i resp, exactly one idle cycle with l2_read=l2_write=0.
  - Then l2_write=1, l2_address=0x8000, l2_wdata=0x1234….
- Sustained contention: both ports re-request immediately, 6 transactions. Required:
  - Grant order I,D,I,D,I,D.
  - Each resp goes only to its owner.
- Mid-transaction requester change: during SERVE_D, change d_pmem_address from 0x8000 to 0x9000. Required: l2_address stays 0x8000 until l2_resp.
- Reset mid-transaction: assert rst_n low while l2_read=1. Required:
  - l2_read, l2_write, and both resp are 0 in the same cycle.
  - After release, state is IDLE and a tie grants I.
- Stray l2_resp in IDLE with no request pending: no resp is issued and the state remains IDLE.
